mips_mc_ctrl: RTL and testbench

Multi-cycle control FSM for the P-series MIPS core. It sequences the IFU, the instruction register, the GRF, the ALU and the DM across FETCH/DECODE/EXEC/MEM/WB states, one instruction at a time. It drives the IFU `branch` select and a single PC-update strobe, so the PC stays stable for the whole instruction. It also counts retired instructions.

---
 rtl/mips_mc_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the P-series MIPS core.
// Rev 1.0 - initial release.
`default_nettype none

module mips_mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       branch,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             alu_src,
  output logic             ext_op,
  output logic [1:0]       alu_op,
  output logic             mem_we,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [3:0] I_ILL  = 4'd0;
  localparam logic [3:0] I_ADDU = 4'd1;
  localparam logic [3:0] I_SUBU = 4'd2;
  localparam logic [3:0] I_JR   = 4'd3;
  localparam logic [3:0] I_NOP  = 4'd4;
  localparam logic [3:0] I_ORI  = 4'd5;
  localparam logic [3:0] I_LUI  = 4'd6;
  localparam logic [3:0] I_LW   = 4'd7;
  localparam logic [3:0] I_SW   = 4'd8;
  localparam logic [3:0] I_BEQ  = 4'd9;
  localparam logic [3:0] I_J    = 4'd10;
  localparam logic [3:0] I_JAL  = 4'd11;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [3:0]       instr;

  // Unmasked outputs; reset gating is applied at the ports.
  logic       ir_we_raw, pc_we_raw, reg_we_raw, mem_we_raw, illegal_raw;
  logic [1:0] branch_raw, reg_dst_raw, wd_sel_raw, alu_op_raw;
  logic       alu_src_raw, ext_op_raw;

  always_comb begin
    instr = I_ILL;
    unique case (opcode)
      6'b000000: begin
        unique case (funct)
          6'b100001: instr = I_ADDU;
          6'b100011: instr = I_SUBU;
          6'b001000: instr = I_JR;
          6'b000000: instr = I_NOP;
          default:   instr = I_ILL;
        endcase
      end
      6'b001101: instr = I_ORI;
      6'b001111: instr = I_LUI;
      6'b100011: instr = I_LW;
      6'b101011: instr = I_SW;
      6'b000100: instr = I_BEQ;
      6'b000010: instr = I_J;
      6'b000011: instr = I_JAL;
      default:   instr = I_ILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = (instr == I_ILL) ? S_FETCH : S_EXEC;
      S_EXEC: begin
        unique case (instr)
          I_ADDU, I_SUBU, I_ORI, I_LUI: state_d = S_WB;
          I_LW, I_SW:                   state_d = S_MEM;
          default:                      state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (instr == I_LW) begin
          state_d = mem_ready ? S_WB : S_MEM;
        end else if (instr == I_SW) begin
          state_d = mem_ready ? S_FETCH : S_MEM;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    retired_d = retired_q;
    if (pc_we_raw && !illegal_raw) begin
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    ir_we_raw   = 1'b0;
    pc_we_raw   = 1'b0;
    branch_raw  = 2'b00;
    reg_we_raw  = 1'b0;
    reg_dst_raw = 2'b00;
    wd_sel_raw  = 2'b00;
    alu_src_raw = 1'b0;
    ext_op_raw  = 1'b0;
    alu_op_raw  = 2'b00;
    mem_we_raw  = 1'b0;
    illegal_raw = 1'b0;
    unique case (state_q)
      S_FETCH: ir_we_raw = 1'b1;
      S_DECODE: begin
        if (instr == I_ILL) begin
          pc_we_raw   = 1'b1;
          illegal_raw = 1'b1;
        end
      end
      S_EXEC: begin
        unique case (instr)
          I_ADDU: alu_op_raw = 2'b00;
          I_SUBU: alu_op_raw = 2'b01;
          I_ORI: begin
            alu_op_raw  = 2'b10;
            alu_src_raw = 1'b1;
          end
          I_LUI: begin
            alu_op_raw  = 2'b11;
            alu_src_raw = 1'b1;
          end
          I_LW, I_SW: begin
            alu_src_raw = 1'b1;
            ext_op_raw  = 1'b1;
          end
          I_BEQ: begin
            alu_op_raw = 2'b01;
            pc_we_raw  = 1'b1;
            branch_raw = 2'b01;
          end
          I_J: begin
            pc_we_raw  = 1'b1;
            branch_raw = 2'b10;
          end
          I_JAL: begin
            pc_we_raw   = 1'b1;
            branch_raw  = 2'b10;
            reg_we_raw  = 1'b1;
            reg_dst_raw = 2'b10;
            wd_sel_raw  = 2'b10;
          end
          I_JR: begin
            pc_we_raw  = 1'b1;
            branch_raw = 2'b11;
          end
          I_NOP: pc_we_raw = 1'b1;
          default: ;
        endcase
      end
      S_MEM: begin
        // Address path stays on base+sext(imm) for the whole access.
        alu_src_raw = 1'b1;
        ext_op_raw  = 1'b1;
        if (instr == I_SW) begin
          mem_we_raw = 1'b1;
          pc_we_raw  = mem_ready;
        end
      end
      S_WB: begin
        reg_we_raw = 1'b1;
        pc_we_raw  = 1'b1;
        unique case (instr)
          I_ADDU, I_SUBU: reg_dst_raw = 2'b01;
          I_LW:           wd_sel_raw  = 2'b01;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign ir_we   = reset & ir_we_raw;
  assign pc_we   = reset & pc_we_raw;
  assign reg_we  = reset & reg_we_raw;
  assign mem_we  = reset & mem_we_raw;
  assign illegal = reset & illegal_raw;
  assign branch  = reset ? branch_raw  : 2'b00;
  assign reg_dst = reset ? reg_dst_raw : 2'b00;
  assign wd_sel  = reset ? wd_sel_raw  : 2'b00;
  assign alu_src = reset & alu_src_raw;
  assign ext_op  = reset & ext_op_raw;
  assign alu_op  = reset ? alu_op_raw  : 2'b00;
  assign state   = reset ? state_q     : S_FETCH;
  assign retired = reset ? retired_q   : '0;

endmodule

`default_nettype wire

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: directed self-checking bench for mips_mc_ctrl.
`default_nettype none

module tb_mips_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        mem_ready = 1'b0;
  logic        ir_we, pc_we, reg_we, mem_we, illegal, alu_src, ext_op;
  logic [1:0]  branch, reg_dst, wd_sel, alu_op;
  logic [2:0]  state;
  logic [31:0] retired;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_ret = 32'd0;

  mips_mc_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .branch(branch), .reg_we(reg_we), .reg_dst(reg_dst),
    .wd_sel(wd_sel), .alu_src(alu_src), .ext_op(ext_op), .alu_op(alu_op), .mem_we(mem_we),
    .illegal(illegal), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  // {ir_we,pc_we,branch,reg_we,reg_dst,wd_sel,alu_src,ext_op,alu_op,mem_we,illegal,state}
  wire [17:0] obs = {ir_we, pc_we, branch, reg_we, reg_dst, wd_sel,
                     alu_src, ext_op, alu_op, mem_we, illegal, state};

  function automatic logic [17:0] v(input logic ir, input logic pc, input logic [1:0] br,
                                    input logic rw, input logic [1:0] rd, input logic [1:0] wd,
                                    input logic as, input logic eo, input logic [1:0] ao,
                                    input logic mw, input logic il, input logic [2:0] st);
    return {ir, pc, br, rw, rd, wd, as, eo, ao, mw, il, st};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    opcode = 6'b100011;
    repeat (3) tick();
    #1;
    checks++;
    if (obs !== 18'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%05h exp=%05h", obs, 18'd0);
    end
    checks++;
    if (retired !== 32'd0) begin
      failures++;
      $display("FAIL reset_retired got=%0d exp=0", retired);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== v(1,0,2'b00,0,2'b00,2'b00,0,0,2'b00,0,0,3'd0)) begin
      failures++;
      $display("FAIL reset_release got=%05h exp=%05h", obs, v(1,0,2'b00,0,2'b00,2'b00,0,0,2'b00,0,0,3'd0));
    end
  endtask

  task automatic test_addu;
    logic [17:0] e [4];
    e[0] = v(1,0,2'b00,0,2'b00,2'b00,0,0,2'b00,0,0,3'd0);
    e[1] = v(0,0,2'b00,0,2'b00,2'b00,0,0,2'b00,0,0,3'd1);
    e[2] = v(0,0,2'b00,0,2'b00,2'b00,0,0,2'b00,0,0,3'd2);
    e[3] = v(0,1,2'b00,1,2'b01,2'b00,0,0,2'b00,0,0,3'd4);
    opcode = 6'b000000; funct = 6'b100001; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL addu_cyc%0d got=%05h exp=%05h", i, obs, e[i]);
      end
    end
    tick();
    exp_ret = exp_ret + 1;
    checks++;
    if (state !== 3'd0 || retired !== exp_ret) begin
      failures++;
      $display("FAIL addu_end state=%0d retired=%0d exp state=0 retired=%0d", state, retired, exp_ret);
    end
  endtask

  task automatic test_alu_ops;
    logic [5:0] ops [3];
    logic [5:0] fns [3];
    logic [17:0] ex [3];
    logic [17:0] wb [3];
    ops[0] = 6'b000000; fns[0] = 6'b100011;
    ex[0] = v(0,0,2'b00,0,2'b00,2'b00,0,0,2'b01,0,0,3'd2);
    wb[0] = v(0,1,2'b00,1,2'b01,2'b00,0,0,2'b00,0,0,3'd4);
    ops[1] = 6'b001101; fns[1] = 6'b111111;
    ex[1] = v(0,0,2'b00,0,2'b00,2'b00,1,0,2'b10,0,0,3'd2);
    wb[1] = v(0,1,2'b00,1,2'b00,2'b00,0,0,2'b00,0,0,3'd4);
    ops[2] = 6'b001111; fns[2] = 6'b100001;
    ex[2] = v(0,0,2'b00,0,2'b00,2'b00,1,0,2'b11,0,0,3'd2);
    wb[2] = v(0,1,2'b00,1,2'b00,2'b00,0,0,2'b00,0,0,3'd4);
    for (int k = 0; k < 3; k++) begin
      opcode = ops[k]; funct = fns[k];
      tick(); tick(); #1;
      checks++;
      if (obs !== ex[k]) begin
        failures++;
        $display("FAIL alu%0d_exec got=%05h exp=%05h", k, obs, ex[k]);
      end
      tick(); #1;
      checks++;
      if (obs !== wb[k]) begin
        failures++;
        $display("FAIL alu%0d_wb got=%05h exp=%05h", k, obs, wb[k]);
      end
      tick();
      exp_ret = exp_ret + 1;
    end
    checks++;
    if (retired !== exp_ret) begin
      failures++;
      $display("FAIL alu_retired got=%0d exp=%0d", retired, exp_ret);
    end
  endtask

  task automatic test_lw_wait;
    logic [17:0] e [8];
    logic        mr [8];
    int          pc_cnt;
    pc_cnt = 0;
    e[0] = v(1,0,2'b00,0,2'b00,2'b00,0,0,2'b00,0,0,3'd0); mr[0] = 0;
    e[1] = v(0,0,2'b00,0,2'b00,2'b00,0,0,2'b00,0,0,3'd1); mr[1] = 1;
    e[2] = v(0,0,2'b00,0,2'b00,2'b00,1,1,2'b00,0,0,3'd2); mr[2] = 1;
    e[3] = v(0,0,2'b00,0,2'b00,2'b00,1,1,2'b00,0,0,3'd3); mr[3] = 0;
    e[4] = v(0,0,2'b00,0,2'b00,2'b00,1,1,2'b00,0,0,3'd3); mr[4] = 0;
    e[5] = v(0,0,2'b00,0,2'b00,2'b00,1,1,2'b00,0,0,3'd3); mr[5] = 1;
    e[6] = v(0,1,2'b00,1,2'b00,2'b01,0,0,2'b00,0,0,3'd4); mr[6] = 0;
    e[7] = v(1,0,2'b00,0,2'b00,2'b00,0,0,2'b00,0,0,3'd0); mr[7] = 0;
    opcode = 6'b100011; funct = 6'b000000;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      mem_ready = mr[i];
      #1;
      if (i < 7 && pc_we === 1'b1) pc_cnt++;
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL lw_cyc%0d got=%05h exp=%05h", i, obs, e[i]);
      end
    end
    exp_ret = exp_ret + 1;
    checks++;
    if (pc_cnt !== 1 || retired !== exp_ret) begin
      failures++;
      $display("FAIL lw_commit pc_we_cycles=%0d retired=%0d exp 1 and %0d", pc_cnt, retired, exp_ret);
    end
  endtask

  task automatic test_sw;
    logic [17:0] mem_wait, mem_done;
    int          rw_seen;
    rw_seen = 0;
    mem_wait = v(0,0,2'b00,0,2'b00,2'b00,1,1,2'b00,1,0,3'd3);
    mem_done = v(0,1,2'b00,0,2'b00,2'b00,1,1,2'b00,1,0,3'd3);
    opcode = 6'b101011; funct = 6'b000000; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      #1;
      if (reg_we === 1'b1) rw_seen++;
    end
    tick(); #1;
    checks++;
    if (obs !== mem_done) begin
      failures++;
      $display("FAIL sw_mem_ready got=%05h exp=%05h", obs, mem_done);
    end
    tick(); #1;
    exp_ret = exp_ret + 1;
    checks++;
    if (state !== 3'd0 || rw_seen !== 0 || retired !== exp_ret) begin
      failures++;
      $display("FAIL sw_end state=%0d reg_we_seen=%0d retired=%0d exp 0,0,%0d", state, rw_seen, retired, exp_ret);
    end
    tick(); tick(); tick();
    mem_ready = 1'b0; #1;
    checks++;
    if (obs !== mem_wait) begin
      failures++;
      $display("FAIL sw_mem_wait got=%05h exp=%05h", obs, mem_wait);
    end
    tick(); mem_ready = 1'b1; #1;
    checks++;
    if (obs !== mem_done) begin
      failures++;
      $display("FAIL sw_mem_late got=%05h exp=%05h", obs, mem_done);
    end
    tick();
    exp_ret = exp_ret + 1;
  endtask

  task automatic test_jumps;
    logic [5:0]  ops [5];
    logic [5:0]  fns [5];
    logic [17:0] ex [5];
    ops[0] = 6'b000011; fns[0] = 6'b000000;
    ex[0] = v(0,1,2'b10,1,2'b10,2'b10,0,0,2'b00,0,0,3'd2);
    ops[1] = 6'b000000; fns[1] = 6'b001000;
    ex[1] = v(0,1,2'b11,0,2'b00,2'b00,0,0,2'b00,0,0,3'd2);
    ops[2] = 6'b000100; fns[2] = 6'b000000;
    ex[2] = v(0,1,2'b01,0,2'b00,2'b00,0,0,2'b01,0,0,3'd2);
    ops[3] = 6'b000010; fns[3] = 6'b000000;
    ex[3] = v(0,1,2'b10,0,2'b00,2'b00,0,0,2'b00,0,0,3'd2);
    ops[4] = 6'b000000; fns[4] = 6'b000000;
    ex[4] = v(0,1,2'b00,0,2'b00,2'b00,0,0,2'b00,0,0,3'd2);
    for (int k = 0; k < 5; k++) begin
      opcode = ops[k]; funct = fns[k];
      tick(); tick(); #1;
      checks++;
      if (obs !== ex[k]) begin
        failures++;
        $display("FAIL jump%0d_exec got=%05h exp=%05h", k, obs, ex[k]);
      end
      tick();
      exp_ret = exp_ret + 1;
      checks++;
      if (state !== 3'd0 || retired !== exp_ret) begin
        failures++;
        $display("FAIL jump%0d_end state=%0d retired=%0d exp 0,%0d", k, state, retired, exp_ret);
      end
    end
  endtask

  task automatic test_illegal;
    logic [17:0] dec_ill;
    logic [5:0]  ops [2];
    logic [5:0]  fns [2];
    dec_ill = v(0,1,2'b00,0,2'b00,2'b00,0,0,2'b00,0,1,3'd1);
    ops[0] = 6'b111111; fns[0] = 6'b000000;
    ops[1] = 6'b000000; fns[1] = 6'b100000;
    for (int k = 0; k < 2; k++) begin
      opcode = ops[k]; funct = fns[k];
      tick(); #1;
      checks++;
      if (obs !== dec_ill) begin
        failures++;
        $display("FAIL illegal%0d_decode got=%05h exp=%05h", k, obs, dec_ill);
      end
      tick(); #1;
      checks++;
      if (state !== 3'd0 || ir_we !== 1'b1 || retired !== exp_ret) begin
        failures++;
        $display("FAIL illegal%0d_end state=%0d ir_we=%0b retired=%0d exp 0,1,%0d", k, state, ir_we, retired, exp_ret);
      end
    end
  endtask

  task automatic test_reset_in_mem;
    opcode = 6'b100011; funct = 6'b000000; mem_ready = 1'b0;
    tick(); tick(); tick(); #1;
    checks++;
    if (state !== 3'd3) begin
      failures++;
      $display("FAIL rstmem_reach got=%0d exp=3", state);
    end
    reset = 1'b0; mem_ready = 1'b1; #1;
    checks++;
    if (obs !== 18'd0) begin
      failures++;
      $display("FAIL rstmem_abort got=%05h exp=%05h", obs, 18'd0);
    end
    tick();
    reset = 1'b1; #1;
    exp_ret = 32'd0;
    checks++;
    if (obs !== v(1,0,2'b00,0,2'b00,2'b00,0,0,2'b00,0,0,3'd0) || retired !== exp_ret) begin
      failures++;
      $display("FAIL rstmem_release got=%05h retired=%0d exp=%05h retired=0", obs, retired, v(1,0,2'b00,0,2'b00,2'b00,0,0,2'b00,0,0,3'd0));
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_alu_ops();
    test_lw_wait();
    test_sw();
    test_jumps();
    test_illegal();
    test_reset_in_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
